// File: rtl/rr_arbiter_8_pkg.sv
// Shared constants, state encoding and circular winner search for the 8-way round-robin arbiter.
package rr_arbiter_8_pkg;

  localparam int NUM_REQ = 8;
  localparam int ID_W    = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // First set bit of req searching last+1, last+2, ... and finally last itself.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] idx;
    logic            found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = last + ID_W'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter_8_dec3to8.sv
// Combinational 3-to-8 one-hot decoder.
module dec3to8
  import rr_arbiter_8_pkg::*;
(
  input  logic [ID_W-1:0]    id_i,
  output logic [NUM_REQ-1:0] onehot_o
);

  always_comb begin
    onehot_o       = '0;
    onehot_o[id_i] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with registered grant and MAX_HOLD-cycle preemption.
// Grant appears one cycle after request; all outputs come from registers or their decode.
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid,
  output logic               preempt
);

  localparam int              CNT_W   = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               preempt_q, preempt_d;

  logic [NUM_REQ-1:0] id_oh;
  logic [NUM_REQ-1:0] others;
  logic [NUM_REQ-1:0] pick_src;
  logic [ID_W-1:0]    next_id;
  logic               holding;

  dec3to8 u_dec (
    .id_i     (id_q),
    .onehot_o (id_oh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      id_q      <= '0;
      last_q    <= ID_W'(NUM_REQ - 1);
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  // While granting, last_q equals id_q, so masking the holder excludes it from this search.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
    others    = req & ~id_oh;
    holding   = req[id_q];
    pick_src  = (state_q == GRANT) ? others : req;
    next_id   = rr_pick(pick_src, last_q);

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          id_d    = next_id;
          last_d  = next_id;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!holding) begin
          cnt_d = '0;
          if (|others) begin
            id_d   = next_id;
            last_d = next_id;
          end else begin
            state_d = IDLE;
            id_d    = '0;
          end
        end else if (cnt_q == CNT_MAX) begin
          if (|others) begin
            id_d      = next_id;
            last_d    = next_id;
            cnt_d     = '0;
            preempt_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt_valid = (state_q == GRANT);
  assign gnt_id    = id_q;
  assign gnt       = id_oh & {NUM_REQ{gnt_valid}};
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8 with MAX_HOLD=4: directed scenarios plus random traffic.
module tb_rr_arbiter_8;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       preempt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who holds, for how long, and who was granted last.
  bit m_valid;
  int m_id;
  int m_last;
  int m_cnt;
  bit m_pre;

  logic [12:0] dut_vec;
  assign dut_vec = {gnt, gnt_id, gnt_valid, preempt};

  rr_arbiter_8 #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [7:0] r, input int from);
    for (int k = 1; k <= 8; k++)
      if (r[(from + k) % 8]) return (from + k) % 8;
    return from;
  endfunction

  function automatic logic [12:0] model_vec();
    logic [7:0] g;
    g = m_valid ? 8'(1 << m_id) : 8'h00;
    return {g, m_valid ? 3'(m_id) : 3'd0, m_valid, m_pre};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_last = 7; m_cnt = 0; m_pre = 0;
  endtask

  task automatic model_step(input logic [7:0] r);
    logic [7:0] others;
    m_pre = 0;
    if (!m_valid) begin
      if (r != 8'h00) begin
        m_id = pick(r, m_last); m_last = m_id; m_valid = 1; m_cnt = 0;
      end
    end else begin
      others = r;
      others[m_id] = 1'b0;
      if (!r[m_id]) begin
        if (others != 8'h00) begin
          m_id = pick(others, m_id); m_last = m_id; m_cnt = 0;
        end else begin
          m_valid = 0; m_id = 0; m_cnt = 0;
        end
      end else if (m_cnt >= MH - 1) begin
        if (others != 8'h00) begin
          m_id = pick(others, m_id); m_last = m_id; m_cnt = 0; m_pre = 1;
        end
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic step(input logic [7:0] r);
    req = r;
    model_step(r);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'h00;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    model_reset();
    @(negedge clk);
    n_checks++;
    if (dut_vec !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h", dut_vec, 13'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_grant();
    step(8'h01);
    n_checks++;
    if (dut_vec !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL first_grant: got %h want %h", dut_vec, {8'h01, 3'd0, 1'b1, 1'b0});
    end
    step(8'h00);
    n_checks++;
    if (dut_vec !== 13'h0) begin
      n_fail++;
      $display("FAIL release_to_idle: got %h want %h", dut_vec, 13'h0);
    end
  endtask

  task automatic test_round_robin();
    logic [12:0] exp;
    do_reset();
    step(8'hFF);
    for (int i = 0; i <= 8; i++) begin
      exp = {8'(1 << (i % 8)), 3'(i % 8), 1'b1, 1'b0};
      n_checks++;
      if (dut_vec !== exp) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got %h want %h", i, dut_vec, exp);
      end
      if (i < 8) step(8'hFF & ~8'(1 << (i % 8)));
    end
  endtask

  task automatic test_preempt();
    do_reset();
    step(8'h04);
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (dut_vec !== {8'h04, 3'd2, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL preempt_hold[%0d]: got %h want %h", c, dut_vec, {8'h04, 3'd2, 1'b1, 1'b0});
      end
      step(8'h24);
    end
    n_checks++;
    if (dut_vec !== {8'h20, 3'd5, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL preempt_switch: got %h want %h", dut_vec, {8'h20, 3'd5, 1'b1, 1'b1});
    end
    step(8'h24);
    n_checks++;
    if (dut_vec !== {8'h20, 3'd5, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL preempt_one_cycle: got %h want %h", dut_vec, {8'h20, 3'd5, 1'b1, 1'b0});
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      step(8'h08);
      n_checks++;
      if (dut_vec !== {8'h08, 3'd3, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL saturate_hold[%0d]: got %h want %h", c, dut_vec, {8'h08, 3'd3, 1'b1, 1'b0});
      end
    end
    step(8'h09);
    n_checks++;
    if (dut_vec !== {8'h01, 3'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL saturate_preempt: got %h want %h", dut_vec, {8'h01, 3'd0, 1'b1, 1'b1});
    end
  endtask

  task automatic test_reset_midgrant();
    do_reset();
    step(8'h40);
    n_checks++;
    if (dut_vec !== {8'h40, 3'd6, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_setup: got %h want %h", dut_vec, {8'h40, 3'd6, 1'b1, 1'b0});
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut_vec !== 13'h0) begin
      n_fail++;
      $display("FAIL midreset_async_drop: got %h want %h", dut_vec, 13'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(8'h40);
    n_checks++;
    if (dut_vec !== {8'h40, 3'd6, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_regrant: got %h want %h", dut_vec, {8'h40, 3'd6, 1'b1, 1'b0});
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    int         wt[8];
    int         worst;
    bit         dec_ok;
    do_reset();
    r = 8'h00;
    for (int k = 0; k < 8; k++) wt[k] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int k = 0; k < 8; k++) begin
        if (!r[k]) r[k] = ($urandom_range(3) == 0);
        else if (m_valid && m_id == k && $urandom_range(2) == 0) r[k] = 1'b0;
      end
      step(r);
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL rand_model[%0d]: got %h want %h", cyc, dut_vec, model_vec());
      end
      n_checks++;
      if (!$onehot0(gnt)) begin
        n_fail++;
        $display("FAIL rand_onehot[%0d]: got %h want one-hot or zero", cyc, gnt);
      end
      dec_ok = gnt_valid ? (gnt == 8'(1 << gnt_id)) : (gnt == 8'h00);
      n_checks++;
      if (!dec_ok) begin
        n_fail++;
        $display("FAIL rand_decode[%0d]: got gnt %h id %0d valid %0b", cyc, gnt, gnt_id, gnt_valid);
      end
      worst = 0;
      for (int k = 0; k < 8; k++) begin
        if (r[k] && !gnt[k]) wt[k]++;
        else wt[k] = 0;
        if (wt[k] > worst) worst = wt[k];
      end
      n_checks++;
      if (worst > 7 * MH) begin
        n_fail++;
        $display("FAIL rand_starvation[%0d]: got wait %0d want <= %0d", cyc, worst, 7 * MH);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_grant();
    test_round_robin();
    test_preempt();
    test_saturate();
    test_reset_midgrant();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
